// File: rtl/alarm_pkg.sv
// alarm_pkg: state width and state encodings shared by the alarm sequencer and its bench
package alarm_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;
endpackage

// File: rtl/delay_timer.sv
// delay_timer: prescaled loadable down-counter; clk/rst, load+load_value start a count, clear zeroes it, expired strobes on the final tick, count is the remaining ticks
module delay_timer #(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired,
  output logic [WIDTH-1:0] count
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc;
  logic          tick;
  assign tick    = count != '0 && presc == PW'(PRESCALE - 1);
  assign expired = tick && count == WIDTH'(1);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      presc <= '0;
    end else if (load) begin
      count <= load_value;
      presc <= '0;
    end else if (count != '0) begin
      presc <= tick ? '0 : presc + PW'(1);
      count <= tick ? count - WIDTH'(1) : count;
    end
  end
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm FSM on clock50/Mr_n with arm, code_ok, sensor inputs; state, countdown, Tc registered, siren and armed_led decoded from state
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int PRESCALE    = 4,
  parameter int EXIT_TICKS  = 3,
  parameter int ENTRY_TICKS = 2,
  parameter int SIREN_TICKS = 5
) (
  input  logic               clock50,
  input  logic               Mr_n,
  input  logic               arm,
  input  logic               code_ok,
  input  logic               sensor,
  output logic [STATE_W-1:0] state,
  output logic [WIDTH-1:0]   countdown,
  output logic               Tc,
  output logic               siren,
  output logic               armed_led
);
  state_t           state_q, nxt, seq;
  logic             load, clear, expired;
  logic [WIDTH-1:0] load_value;
  always_ff @(posedge clock50) begin
    if (!Mr_n) begin
      state_q <= DISARMED;
      Tc      <= 1'b0;
    end else begin
      state_q <= nxt;
      Tc      <= expired && nxt != DISARMED;
    end
  end
  always_comb begin
    seq = DISARMED;
    case (state_q)
      DISARMED:    seq = arm     ? EXIT_DELAY  : DISARMED;
      EXIT_DELAY:  seq = expired ? ARMED       : EXIT_DELAY;
      ARMED:       seq = sensor  ? ENTRY_DELAY : ARMED;
      ENTRY_DELAY: seq = expired ? ALARM       : ENTRY_DELAY;
      ALARM:       seq = expired ? ARMED       : ALARM;
      default:     seq = DISARMED;
    endcase
    nxt        = code_ok ? DISARMED : seq;
    load       = nxt != state_q && (nxt == EXIT_DELAY || nxt == ENTRY_DELAY || nxt == ALARM);
    load_value = nxt == EXIT_DELAY  ? WIDTH'(EXIT_TICKS)  :
                 nxt == ENTRY_DELAY ? WIDTH'(ENTRY_TICKS) : WIDTH'(SIREN_TICKS);
    clear      = nxt == DISARMED || nxt == ARMED;
  end
  delay_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) u_timer (
    .clk       (clock50),
    .rst       (!Mr_n),
    .load      (load),
    .clear     (clear),
    .load_value(load_value),
    .expired   (expired),
    .count     (countdown)
  );
  assign state     = state_q;
  assign siren     = state_q == ALARM;
  assign armed_led = state_q != DISARMED;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: vector table, directed corner sequences and random stimulus against a cycle-count reference model
module tb_alarm_sequencer;
  import alarm_pkg::*;
  localparam int W = 10, P = 4, EX = 3, EN = 2, SI = 5;
  logic           clock50 = 1'b0, Mr_n = 1'b0, arm = 1'b0, code_ok = 1'b0, sensor = 1'b0;
  logic [2:0]     state;
  logic [W-1:0]   countdown;
  logic           Tc, siren, armed_led;
  int             checks = 0, errors = 0;
  int             m_s = 0, m_cl = 0, m_tc = 0;
  typedef struct {
    bit r, a, c, s;
    int st, cd, tc;
  } vec_t;
  vec_t tbl[16];
  always #5 clock50 = ~clock50;
  alarm_sequencer #(
    .WIDTH(W), .PRESCALE(P), .EXIT_TICKS(EX), .ENTRY_TICKS(EN), .SIREN_TICKS(SI)
  ) dut (
    .clock50  (clock50),
    .Mr_n     (Mr_n),
    .arm      (arm),
    .code_ok  (code_ok),
    .sensor   (sensor),
    .state    (state),
    .countdown(countdown),
    .Tc       (Tc),
    .siren    (siren),
    .armed_led(armed_led)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    bit ex;
    ex = (m_s == 1 || m_s == 3 || m_s == 4) && m_cl == 1;
    if (!Mr_n || code_ok) begin
      m_s = 0; m_cl = 0; m_tc = 0;
    end else begin
      m_tc = ex;
      if (m_s == 0) begin
        if (arm) begin m_s = 1; m_cl = EX * P; end
      end else if (m_s == 2) begin
        if (sensor) begin m_s = 3; m_cl = EN * P; end
      end else if (ex) begin
        m_s  = m_s == 3 ? 4 : 2;
        m_cl = m_s == 4 ? SI * P : 0;
      end else m_cl--;
    end
  endtask
  task automatic step(input bit r, input bit a, input bit c, input bit s);
    @(negedge clock50);
    Mr_n = r; arm = a; code_ok = c; sensor = s;
    @(posedge clock50);
    model_edge();
    #1;
    check("state", state, m_s);
    check("countdown", countdown, (m_cl + P - 1) / P);
    check("tc", Tc, m_tc);
    check("siren", siren, m_s == 4);
    check("armed_led", armed_led, m_s != 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask
  initial begin
    tbl = '{
      '{0,0,0,0, 0,0,0}, '{1,1,0,0, 1,3,0}, '{1,0,0,0, 1,3,0}, '{1,0,0,0, 1,3,0},
      '{1,0,0,0, 1,3,0}, '{1,0,0,0, 1,2,0}, '{1,0,0,0, 1,2,0}, '{1,0,0,0, 1,2,0},
      '{1,0,0,0, 1,2,0}, '{1,0,0,0, 1,1,0}, '{1,0,0,0, 1,1,0}, '{1,0,0,0, 1,1,0},
      '{1,0,0,0, 1,1,0}, '{1,0,0,0, 2,0,1}, '{1,0,0,0, 2,0,0}, '{1,0,0,1, 3,2,0}
    };
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].s);
      check("tbl_state", state, tbl[i].st);
      check("tbl_countdown", countdown, tbl[i].cd);
      check("tbl_tc", Tc, tbl[i].tc);
    end
    idle(7);
    check("entry_hold", state, 3);
    idle(1);
    check("alarm_state", state, 4);
    check("alarm_siren", siren, 1);
    check("alarm_countdown", countdown, 5);
    idle(19);
    check("alarm_hold", state, 4);
    idle(1);
    check("rearm_state", state, 2);
    check("rearm_siren", siren, 0);
    check("rearm_tc", Tc, 1);
    step(1, 0, 0, 1);
    idle(4);
    step(1, 0, 1, 0);
    check("abort_state", state, 0);
    check("abort_countdown", countdown, 0);
    check("abort_tc", Tc, 0);
    check("abort_led", armed_led, 0);
    idle(1);
    check("abort_tc_after", Tc, 0);
    step(1, 1, 1, 0);
    check("arm_and_code", state, 0);
    step(1, 1, 0, 0);
    idle(12);
    check("armed_again", state, 2);
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    check("alarm_sensor_in", state, 4);
    for (int i = 0; i < 19; i++) begin
      step(1, 0, 0, 1);
      check("alarm_sensor_hold", state, 4);
    end
    step(1, 0, 0, 1);
    check("alarm_sensor_exit", state, 2);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    idle(12);
    step(1, 0, 0, 1);
    idle(8);
    check("alarm_for_reset", state, 4);
    begin
      int n = 0;
      while (countdown != 3 && n < 30) begin idle(1); n++; end
      check("wait_countdown3", countdown, 3);
    end
    step(0, 1, 0, 0);
    check("reset_state", state, 0);
    check("reset_siren", siren, 0);
    check("reset_countdown", countdown, 0);
    check("reset_tc", Tc, 0);
    step(1, 0, 1, 0);
    @(negedge clock50);
    force dut.state_q = state_t'(3'd6);
    #1;
    release dut.state_q;
    check("forced_code", state, 6);
    @(posedge clock50);
    #1;
    check("recover_state", state, 0);
    check("recover_countdown", countdown, 0);
    check("recover_tc", Tc, 0);
    check("recover_siren", siren, 0);
    check("recover_led", armed_led, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) != 0, $urandom_range(3) == 0,
           $urandom_range(15) == 0, $urandom_range(2) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
